// File: rtl/gift_pkg.sv
// Shared constants for the GIFT-128 decryption key schedule.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gift_pkg;

    localparam int ROUNDS  = 40;   // GIFT-128 round count
    localparam int KEY_W   = 128;  // key state width, k7..k0 as 16-bit words
    localparam int CONST_W = 6;    // round-constant LFSR width

    localparam logic [CONST_W-1:0] LFSR_SEED = 6'h01;

    // Scheduler state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_REV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/gift_key_step.sv
// One GIFT-128 key-state and round-constant update, forward or inverse.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   inv     - 0 selects the forward update, 1 selects the inverse update
//   key_in  - current key state k7..k0 (k7 = bits 127:112)
//   rc_in   - current round constant c5..c0
//   key_out - updated key state
//   rc_out  - updated round constant
module gift_key_step
    import gift_pkg::*;
(
    input  logic               inv,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [CONST_W-1:0] rc_in,
    output logic [KEY_W-1:0]   key_out,
    output logic [CONST_W-1:0] rc_out
);

    logic [15:0]        k1;
    logic [15:0]        k0;
    logic [15:0]        n7;
    logic [15:0]        n6;
    logic [KEY_W-1:0]   key_fwd;
    logic [KEY_W-1:0]   key_inv;
    logic [CONST_W-1:0] rc_fwd;
    logic [CONST_W-1:0] rc_inv;

    always_comb begin
        k1 = key_in[31:16];
        k0 = key_in[15:0];
        n7 = key_in[127:112];
        n6 = key_in[111:96];

        // Forward: new = (k1 >>> 2) || (k0 >>> 12) || k7..k2
        key_fwd = {k1[1:0], k1[15:2], k0[11:0], k0[15:12], key_in[127:32]};

        // Inverse: k7..k2 = new5..new0, k1 = new7 <<< 2, k0 = new6 <<< 12
        key_inv = {key_in[95:0], n7[13:0], n7[15:14], n6[3:0], n6[15:4]};

        // Forward LFSR shifts left and feeds c5^c4^1 into c0; the inverse
        // recovers the old c5 from the new c0 and new c5.
        rc_fwd = {rc_in[4:0], rc_in[5] ^ rc_in[4] ^ 1'b1};
        rc_inv = {rc_in[0] ^ rc_in[5] ^ 1'b1, rc_in[5:1]};

        key_out = inv ? key_inv : key_fwd;
        rc_out  = inv ? rc_inv  : rc_fwd;
    end

endmodule

// File: rtl/gift_inv_key_sched.sv
// GIFT-128 decryption key scheduler: winds the key forward, then replays it backwards.
// Latency: first round key valid ROUNDS-1 cycles after start; one round per accepted inNext.
// Backpressure: without inNext the current round key/constant/round hold indefinitely.
//
// Ports:
//   inClk       - clock, all state changes on the rising edge
//   inRstN      - asynchronous active-low reset
//   inStart     - begin a sequence (only honoured in IDLE); inKey sampled then
//   inKey       - 128-bit master key k7..k0
//   inNext      - consumer has used the current round key (ignored unless outValid)
//   outKey      - key state for outRound (0 when not valid)
//   outConstant - round constant for outRound (0 when not valid)
//   outRound    - current round, ROUNDS down to 1 (0 when not valid)
//   outValid    - outputs above are valid (REV state only)
//   outBusy     - any state other than IDLE
//   outDone     - one-cycle pulse after round 1 has been consumed
module gift_inv_key_sched #(
    parameter int ROUNDS = 40
) (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inStart,
    input  logic [127:0] inKey,
    input  logic         inNext,
    output logic [127:0] outKey,
    output logic [5:0]   outConstant,
    output logic [5:0]   outRound,
    output logic         outValid,
    output logic         outBusy,
    output logic         outDone
);
    import gift_pkg::*;

    localparam logic [5:0] LAST_ROUND = ROUNDS[5:0];

    logic [1:0]         state;
    logic [KEY_W-1:0]   key_q;
    logic [CONST_W-1:0] rc_q;
    logic [5:0]         cnt_q;
    logic [KEY_W-1:0]   key_nxt;
    logic [CONST_W-1:0] rc_nxt;
    logic               in_rev;

    assign in_rev = (state == ST_REV);

    // A single step unit serves both phases: forward while winding up,
    // inverse while handing out round keys.
    gift_key_step u_step (
        .inv     (in_rev),
        .key_in  (key_q),
        .rc_in   (rc_q),
        .key_out (key_nxt),
        .rc_out  (rc_nxt)
    );

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state <= ST_IDLE;
            key_q <= '0;
            rc_q  <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inStart) begin
                        key_q <= inKey;
                        rc_q  <= LFSR_SEED;
                        cnt_q <= 6'd1;
                        // A one-round schedule has nothing to wind forward.
                        state <= (LAST_ROUND == 6'd1) ? ST_REV : ST_FWD;
                    end
                end
                ST_FWD: begin
                    key_q <= key_nxt;
                    rc_q  <= rc_nxt;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == LAST_ROUND) begin
                        state <= ST_REV;
                    end
                end
                ST_REV: begin
                    if (inNext) begin
                        if (cnt_q > 6'd1) begin
                            key_q <= key_nxt;
                            rc_q  <= rc_nxt;
                            cnt_q <= cnt_q - 6'd1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are masked to zero outside REV so stale state never leaks.
    assign outValid    = in_rev;
    assign outKey      = in_rev ? key_q : '0;
    assign outConstant = in_rev ? rc_q  : '0;
    assign outRound    = in_rev ? cnt_q : '0;
    assign outBusy     = (state != ST_IDLE);
    assign outDone     = (state == ST_DONE);

endmodule
